// File: rtl/memory_responder.sv
// Memory target for the core's fetch and load/store ports: one outstanding request per
// port, arbitrated (data port first) onto a single-port word RAM with a fixed latency.
module memory_responder #(
  parameter int    ADDR_WIDTH = 14,
  parameter int    LATENCY    = 1,
  parameter string MEM_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inst_start,
  output logic        inst_ready,
  input  logic [31:0] i_addr,
  output logic [31:0] inst,
  output logic        inst_valid,
  input  logic        d_cmd_start,
  input  logic        d_cmd_write,
  output logic        d_cmd_ready,
  input  logic [31:0] d_addr,
  input  logic [31:0] wdata,
  input  logic [31:0] wmask,
  output logic [31:0] rdata,
  output logic        rdata_valid
);
  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_D,
    BUSY_I
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [3:0]            cnt;
  logic [3:0]            cnt_next;
  logic                  access_d;
  logic                  access_i;

  logic                  pend_d;
  logic                  pend_i;
  logic                  accept_d;
  logic                  accept_i;
  logic                  d_write_q;
  logic [ADDR_WIDTH-1:0] d_idx_q;
  logic [ADDR_WIDTH-1:0] i_idx_q;
  logic [31:0]           wdata_q;
  logic [31:0]           wmask_q;

  logic [31:0]           mem [DEPTH];

  // Byte-offset and above-index address bits are deliberately ignored (address wrap).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[31:ADDR_WIDTH+2], i_addr[1:0],
                              d_addr[31:ADDR_WIDTH+2], d_addr[1:0]};

  assign inst_ready  = !pend_i;
  assign d_cmd_ready = !pend_d;
  assign accept_i    = inst_start && !pend_i;
  assign accept_d    = d_cmd_start && !pend_d;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    access_d   = 1'b0;
    access_i   = 1'b0;
    unique case (state)
      IDLE: begin
        if (pend_d) begin
          state_next = BUSY_D;
          cnt_next   = CNT_LOAD;
        end else if (pend_i) begin
          state_next = BUSY_I;
          cnt_next   = CNT_LOAD;
        end
      end
      BUSY_D: begin
        if (cnt != '0) begin
          cnt_next = cnt - 4'd1;
        end else begin
          access_d   = 1'b1;
          state_next = IDLE;
        end
      end
      BUSY_I: begin
        if (cnt != '0) begin
          cnt_next = cnt - 4'd1;
        end else begin
          access_i   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      pend_d      <= 1'b0;
      pend_i      <= 1'b0;
      d_write_q   <= 1'b0;
      d_idx_q     <= '0;
      i_idx_q     <= '0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      rdata       <= '0;
      inst        <= '0;
      rdata_valid <= 1'b0;
      inst_valid  <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      rdata_valid <= access_d && !d_write_q;
      inst_valid  <= access_i;

      // Acceptance needs !pend, so it never coincides with that port's own access edge.
      if (accept_d) begin
        pend_d    <= 1'b1;
        d_write_q <= d_cmd_write;
        d_idx_q   <= d_addr[ADDR_WIDTH+1:2];
        wdata_q   <= wdata;
        wmask_q   <= wmask;
      end else if (access_d) begin
        pend_d <= 1'b0;
      end

      if (accept_i) begin
        pend_i  <= 1'b1;
        i_idx_q <= i_addr[ADDR_WIDTH+1:2];
      end else if (access_i) begin
        pend_i <= 1'b0;
      end

      if (access_d && !d_write_q) begin
        rdata <= mem[d_idx_q];
      end
      if (access_i) begin
        inst <= mem[i_idx_q];
      end
    end
  end

  // RAM contents survive reset; a reset forces IDLE asynchronously, so no store can fire.
  always_ff @(posedge clk) begin
    if (access_d && d_write_q) begin
      mem[d_idx_q] <= (mem[d_idx_q] & ~wmask_q) | (wdata_q & wmask_q);
    end
  end

endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: two instances (LATENCY 1 and 3), a request/timeline model
// compared every cycle, plus directed transactions with hand-computed results.
module tb_memory_responder;
    localparam int AW = 10;
    localparam int NI = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    logic        inst_start  [NI];
    logic        inst_ready  [NI];
    logic [31:0] i_addr      [NI];
    logic [31:0] inst        [NI];
    logic        inst_valid  [NI];
    logic        d_cmd_start [NI];
    logic        d_cmd_write [NI];
    logic        d_cmd_ready [NI];
    logic [31:0] d_addr      [NI];
    logic [31:0] wdata       [NI];
    logic [31:0] wmask       [NI];
    logic [31:0] rdata       [NI];
    logic        rdata_valid [NI];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        memory_responder #(
            .ADDR_WIDTH(AW),
            .LATENCY   (g == 0 ? 1 : 3),
            .MEM_FILE  ("")
        ) dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .inst_start (inst_start[g]),
            .inst_ready (inst_ready[g]),
            .i_addr     (i_addr[g]),
            .inst       (inst[g]),
            .inst_valid (inst_valid[g]),
            .d_cmd_start(d_cmd_start[g]),
            .d_cmd_write(d_cmd_write[g]),
            .d_cmd_ready(d_cmd_ready[g]),
            .d_addr     (d_addr[g]),
            .wdata      (wdata[g]),
            .wmask      (wmask[g]),
            .rdata      (rdata[g]),
            .rdata_valid(rdata_valid[g])
        );
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    function automatic void chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endfunction

    // ---------------- behavioural model: request timeline per instance ----------------
    longint      edge_n;
    bit          pend_d_m [NI];
    bit          pend_i_m [NI];
    bit          busy_m   [NI];
    bit          serve_d_m[NI];
    longint      done_m   [NI];
    bit          wr_m     [NI];
    logic [31:0] da_m     [NI];
    logic [31:0] wd_m     [NI];
    logic [31:0] wm_m     [NI];
    logic [31:0] ia_m     [NI];
    bit          exp_iv   [NI];
    bit          exp_rv   [NI];
    logic [31:0] exp_inst [NI];
    logic [31:0] exp_rdata[NI];
    logic [31:0] mm       [NI][1024];

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % (1 << AW));
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            pend_d_m[k]  = 1'b0;
            pend_i_m[k]  = 1'b0;
            busy_m[k]    = 1'b0;
            exp_iv[k]    = 1'b0;
            exp_rv[k]    = 1'b0;
            exp_inst[k]  = '0;
            exp_rdata[k] = '0;
        end
    endtask

    task automatic model_step();
        bit old_d;
        bit old_i;
        int w;
        edge_n++;
        for (int k = 0; k < NI; k++) begin
            old_d     = pend_d_m[k];
            old_i     = pend_i_m[k];
            exp_iv[k] = 1'b0;
            exp_rv[k] = 1'b0;
            if (!busy_m[k]) begin
                if (old_d || old_i) begin
                    busy_m[k]    = 1'b1;
                    serve_d_m[k] = old_d;
                    done_m[k]    = edge_n + ((k == 0) ? 1 : 3);
                end
            end else if (done_m[k] == edge_n) begin
                busy_m[k] = 1'b0;
                if (serve_d_m[k]) begin
                    pend_d_m[k] = 1'b0;
                    w = widx(da_m[k]);
                    if (wr_m[k]) begin
                        mm[k][w] = (mm[k][w] & ~wm_m[k]) | (wd_m[k] & wm_m[k]);
                    end else begin
                        exp_rdata[k] = mm[k][w];
                        exp_rv[k]    = 1'b1;
                    end
                end else begin
                    pend_i_m[k] = 1'b0;
                    exp_inst[k] = mm[k][widx(ia_m[k])];
                    exp_iv[k]   = 1'b1;
                end
            end
            if (d_cmd_start[k] === 1'b1 && !old_d) begin
                pend_d_m[k] = 1'b1;
                wr_m[k]     = d_cmd_write[k];
                da_m[k]     = d_addr[k];
                wd_m[k]     = wdata[k];
                wm_m[k]     = wmask[k];
            end
            if (inst_start[k] === 1'b1 && !old_i) begin
                pend_i_m[k] = 1'b1;
                ia_m[k]     = i_addr[k];
            end
        end
    endtask

    initial begin
        edge_n = 0;
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                for (int k = 0; k < NI; k++) begin
                    chk1($sformatf("dut%0d inst_ready", k), inst_ready[k], !pend_i_m[k]);
                    chk1($sformatf("dut%0d d_cmd_ready", k), d_cmd_ready[k], !pend_d_m[k]);
                    chk1($sformatf("dut%0d inst_valid", k), inst_valid[k], exp_iv[k]);
                    chk1($sformatf("dut%0d rdata_valid", k), rdata_valid[k], exp_rv[k]);
                    chk($sformatf("dut%0d inst", k), inst[k], exp_inst[k]);
                    chk($sformatf("dut%0d rdata", k), rdata[k], exp_rdata[k]);
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic reset_values(input int k, input string tag);
        chk1($sformatf("%s dut%0d inst_ready", tag, k), inst_ready[k], 1'b1);
        chk1($sformatf("%s dut%0d d_cmd_ready", tag, k), d_cmd_ready[k], 1'b1);
        chk1($sformatf("%s dut%0d inst_valid", tag, k), inst_valid[k], 1'b0);
        chk1($sformatf("%s dut%0d rdata_valid", tag, k), rdata_valid[k], 1'b0);
        chk($sformatf("%s dut%0d inst", tag, k), inst[k], 32'h0);
        chk($sformatf("%s dut%0d rdata", tag, k), rdata[k], 32'h0);
    endtask

    // Runs one data request; n = edges from acceptance to completion (valid or ready seen).
    task automatic d_op(input int k, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] wm, output int n, output logic [31:0] rd, output int rv_seen);
        chk1($sformatf("dut%0d d_cmd_ready before request", k), d_cmd_ready[k], 1'b1);
        d_cmd_start[k] = 1'b1;
        d_cmd_write[k] = wr;
        d_addr[k]      = a;
        wdata[k]       = wd;
        wmask[k]       = wm;
        @(posedge clk); #1;
        d_cmd_start[k] = 1'b0;
        n       = 0;
        rv_seen = 0;
        while (n < 40) begin
            @(posedge clk); #1;
            n++;
            if (rdata_valid[k] === 1'b1) rv_seen++;
            if (wr ? (d_cmd_ready[k] === 1'b1) : (rdata_valid[k] === 1'b1)) break;
        end
        rd = rdata[k];
    endtask

    task automatic store(input int k, input logic [31:0] a, input logic [31:0] wd, input logic [31:0] wm);
        int n;
        int rv;
        logic [31:0] rd;
        d_op(k, 1'b1, a, wd, wm, n, rd, rv);
        chk($sformatf("dut%0d store %h ready latency", k, a), 32'(n), (k == 0) ? 32'd2 : 32'd4);
        chk($sformatf("dut%0d store %h rdata_valid pulses", k, a), 32'(rv), 32'd0);
    endtask

    task automatic load_check(input int k, input logic [31:0] a, input logic [31:0] expv);
        int n;
        int rv;
        logic [31:0] rd;
        d_op(k, 1'b0, a, '0, '0, n, rd, rv);
        chk($sformatf("dut%0d load %h latency", k, a), 32'(n), (k == 0) ? 32'd2 : 32'd4);
        chk($sformatf("dut%0d load %h data", k, a), rd, expv);
    endtask

    task automatic fetch_check(input int k, input logic [31:0] a, input logic [31:0] expv);
        int n;
        chk1($sformatf("dut%0d inst_ready before fetch", k), inst_ready[k], 1'b1);
        inst_start[k] = 1'b1;
        i_addr[k]     = a;
        @(posedge clk); #1;
        inst_start[k] = 1'b0;
        n = 0;
        while (n < 40) begin
            @(posedge clk); #1;
            n++;
            if (inst_valid[k] === 1'b1) break;
        end
        chk($sformatf("dut%0d fetch %h latency", k, a), 32'(n), (k == 0) ? 32'd2 : 32'd4);
        chk($sformatf("dut%0d fetch %h data", k, a), inst[k], expv);
    endtask

    task automatic simultaneous(input int k);
        int n;
        int nd;
        int ni;
        logic [31:0] rd;
        logic [31:0] id;
        inst_start[k]  = 1'b1;
        i_addr[k]      = 32'h0;
        d_cmd_start[k] = 1'b1;
        d_cmd_write[k] = 1'b0;
        d_addr[k]      = 32'h4;
        @(posedge clk); #1;
        inst_start[k]  = 1'b0;
        d_cmd_start[k] = 1'b0;
        n  = 0;
        nd = 0;
        ni = 0;
        rd = '0;
        id = '0;
        while (n < 40 && ni == 0) begin
            @(posedge clk); #1;
            n++;
            if (rdata_valid[k] === 1'b1) begin
                nd = n;
                rd = rdata[k];
            end
            if (inst_valid[k] === 1'b1) begin
                ni = n;
                id = inst[k];
            end
        end
        chk($sformatf("dut%0d simul data latency", k), 32'(nd), (k == 0) ? 32'd2 : 32'd4);
        chk($sformatf("dut%0d simul inst after data", k), 32'(ni - nd), (k == 0) ? 32'd2 : 32'd4);
        chk($sformatf("dut%0d simul rdata", k), rd, 32'h0BADCAFE);
        chk($sformatf("dut%0d simul inst", k), id, 32'h00000013);
    endtask

    initial begin
        int prev;
        int pulses;
        for (int k = 0; k < NI; k++) begin
            inst_start[k]  = 1'b0;
            i_addr[k]      = '0;
            d_cmd_start[k] = 1'b0;
            d_cmd_write[k] = 1'b0;
            d_addr[k]      = '0;
            wdata[k]       = '0;
            wmask[k]       = '0;
        end

        // Asynchronous reset before any clock edge
        #1 rst_n = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) reset_values(k, "power-on");
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Latency: word 0 = 0x00000013, then load it back
        for (int k = 0; k < NI; k++) begin
            store(k, 32'h0, 32'h00000013, 32'hFFFFFFFF);
            load_check(k, 32'h0, 32'h00000013);
        end

        // Masked store
        for (int k = 0; k < NI; k++) begin
            store(k, 32'h10, 32'hDEADBEEF, 32'hFFFFFFFF);
            store(k, 32'h10, 32'h00001200, 32'h0000FF00);
            load_check(k, 32'h10, 32'hDEAD12EF);
        end

        // Simultaneous fetch 0x0 and load 0x4
        for (int k = 0; k < NI; k++) begin
            store(k, 32'h4, 32'h0BADCAFE, 32'hFFFFFFFF);
            simultaneous(k);
        end

        // Address wrap at ADDR_WIDTH=10: 0x1010 and 0x0010 are the same word
        for (int k = 0; k < NI; k++) begin
            store(k, 32'h1010, 32'hCAFEF00D, 32'hFFFFFFFF);
            fetch_check(k, 32'h0010, 32'hCAFEF00D);
        end

        // Held fetch start for 20 edges at LATENCY=1
        i_addr[0]     = 32'h10;
        inst_start[0] = 1'b1;
        prev   = 0;
        pulses = 0;
        for (int c = 1; c <= 26; c++) begin
            @(posedge clk); #1;
            if (c == 20) inst_start[0] = 1'b0;
            if (inst_valid[0] === 1'b1) begin
                pulses++;
                chk("held inst data", inst[0], 32'hCAFEF00D);
                if (prev != 0) chk("held pulse spacing", 32'(c - prev), 32'd3);
                prev = c;
            end
        end
        chk("held pulse count", 32'(pulses), 32'd7);

        // Reset one cycle after a store is accepted at LATENCY=3
        store(1, 32'h20, 32'h11111111, 32'hFFFFFFFF);
        d_cmd_start[1] = 1'b1;
        d_cmd_write[1] = 1'b1;
        d_addr[1]      = 32'h20;
        wdata[1]       = 32'h22222222;
        wmask[1]       = 32'hFFFFFFFF;
        @(posedge clk); #1;
        d_cmd_start[1] = 1'b0;
        chk1("mid-store d_cmd_ready busy", d_cmd_ready[1], 1'b0);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        reset_values(1, "mid-store");
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        load_check(1, 32'h20, 32'h11111111);

        repeat (3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
